// File: rtl/riscv_pkg.sv
// Shared core types: data width, fetch FSM states, IF/ID bundle.
// Imported by the fetch stage and its skid buffer.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_INSTR = '0;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {instr, pc} holding slot used while decode is stalled.
// Priority: clear, then load, then drain.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   load,
  input  logic   drain,
  input  if_id_t din,
  output logic   valid,
  output if_id_t dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner and imem req/gnt/rvalid sequencer feeding IF/ID.
// Define FETCH_SEQ_PERF_EN to add fetch_cnt / squash_cnt outputs.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     squash_cnt
`endif
);

  fetch_state_e state, state_nx;

  logic [XLEN-1:0] pc, req_pc, tgt;
  logic fire, stage_free, rsp_ok;
  logic to_skid, drain, space, write_d;
  logic skid_valid, unused_tgt;
  if_id_t skid_q, rsp, d_nx;

  assign tgt        = {PCTargetE[XLEN-1:2], 2'b00};
  assign unused_tgt = ^PCTargetE[1:0];
  assign imem_addr  = pc;
  assign rsp        = '{instr: imem_rdata, pc: req_pc};

  assign stage_free = !ValidD || !StallD;
  assign rsp_ok     = (state == WAIT) && imem_rvalid && !PCSrcE;
  assign drain      = skid_valid && stage_free && !PCSrcE;
  // Skid drains first, so a response arriving then must park in the skid.
  assign to_skid    = rsp_ok && (!stage_free || skid_valid);
  assign write_d    = !PCSrcE && stage_free && (skid_valid || rsp_ok);
  assign d_nx       = skid_valid ? skid_q : rsp;
  assign space      = !to_skid && !(skid_valid && !drain);

  assign imem_req = ((state == REQ) && space)
                 || ((state == WAIT) && rsp_ok && space);
  assign fire = imem_req && imem_gnt;

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT: state_nx = REQ;
      REQ: begin
        if (fire) state_nx = PCSrcE ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid)
          state_nx = (PCSrcE || !fire) ? REQ : WAIT;
        else if (PCSrcE)
          state_nx = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_nx = REQ;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      if (PCSrcE)    pc <= tgt;
      else if (fire) pc <= pc + XLEN'(4);
      if (fire)      req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= RESET_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (PCSrcE) begin
      ValidD <= 1'b0;
    end else if (stage_free) begin
      ValidD <= write_d;
      if (write_d) begin
        InstrD   <= d_nx.instr;
        PCD      <= d_nx.pc;
        PCPlus4D <= d_nx.pc + XLEN'(4);
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (PCSrcE),
    .load  (to_skid),
    .drain (drain),
    .din   (rsp),
    .valid (skid_valid),
    .dout  (skid_q)
  );

`ifdef FETCH_SEQ_PERF_EN
  logic rsp_drop;
  assign rsp_drop = imem_rvalid
                 && (((state == WAIT) && PCSrcE) || (state == DROP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      fetch_cnt  <= fetch_cnt + 32'(write_d);
      squash_cnt <= squash_cnt + 32'(rsp_drop)
                  + 32'(PCSrcE && ValidD)
                  + 32'(PCSrcE && skid_valid);
    end
  end
`endif

endmodule
